// File: rtl/iommu_arbiter.sv
// Round-robin arbiter that funnels NUM_DEV DMA requesters onto a single IOMMU
// translation port, with a per-transaction timeout and a sticky timeout flag.
module iommu_arbiter #(
  parameter int NUM_DEV = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_DEV-1:0]         dev_req,
  input  logic [NUM_DEV*32-1:0]      dev_daddr,
  input  logic [NUM_DEV-1:0]         dev_write_en,
  input  logic [NUM_DEV*32-1:0]      dev_write_data,
  output logic [NUM_DEV-1:0]         dev_ack,
  output logic [31:0]                dev_paddr,
  output logic [31:0]                dev_data,
  output logic                       dev_fault,
  output logic [31:0]                iommu_daddr,
  output logic                       iommu_write_en,
  output logic [31:0]                iommu_write_data,
  output logic                       iommu_translate_request,
  input  logic [31:0]                iommu_paddr,
  input  logic [31:0]                iommu_data_out,
  input  logic                       iommu_translation_done,
  input  logic                       iommu_fault,
  output logic [$clog2(NUM_DEV)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err
);
  localparam int IDW = $clog2(NUM_DEV);
  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT_DONE, RELEASE} state_e;

  // Handshake: dev_req is a level held by the device until its one-cycle
  // dev_ack pulse; iommu_translate_request is a level held until the IOMMU
  // raises iommu_translation_done, and a new request is only issued after
  // done has been seen low again.
  state_e           state_q, state_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic [7:0]       tmo_cnt_q, tmo_cnt_d;
  logic [NUM_DEV-1:0] dev_ack_q, dev_ack_d;
  logic [31:0]      dev_paddr_q, dev_paddr_d;
  logic [31:0]      dev_data_q, dev_data_d;
  logic             dev_fault_q, dev_fault_d;
  logic [31:0]      iommu_daddr_q, iommu_daddr_d;
  logic             iommu_we_q, iommu_we_d;
  logic [31:0]      iommu_wdata_q, iommu_wdata_d;
  logic             iommu_req_q, iommu_req_d;
  logic             timeout_err_q, timeout_err_d;

  logic             sel_found;
  logic [IDW-1:0]   sel_idx;
  logic [31:0]      sel_daddr;
  logic             sel_we;
  logic [31:0]      sel_wdata;
  logic [7:0]       tmo_inc;

  // Search above the last grant first, then wrap to the bottom.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_daddr = '0;
    sel_we    = 1'b0;
    sel_wdata = '0;
    for (int j = 0; j < NUM_DEV; j++) begin
      if (!sel_found && dev_req[j] && (j > int'(last_grant_q))) begin
        sel_found = 1'b1;
        sel_idx   = IDW'(j);
        sel_daddr = dev_daddr[32*j +: 32];
        sel_we    = dev_write_en[j];
        sel_wdata = dev_write_data[32*j +: 32];
      end
    end
    for (int j = 0; j < NUM_DEV; j++) begin
      if (!sel_found && dev_req[j] && (j <= int'(last_grant_q))) begin
        sel_found = 1'b1;
        sel_idx   = IDW'(j);
        sel_daddr = dev_daddr[32*j +: 32];
        sel_we    = dev_write_en[j];
        sel_wdata = dev_write_data[32*j +: 32];
      end
    end
  end

  assign tmo_inc = tmo_cnt_q + 8'd1;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_id_d    = grant_id_q;
    tmo_cnt_d     = tmo_cnt_q;
    dev_ack_d     = '0;
    dev_paddr_d   = dev_paddr_q;
    dev_data_d    = dev_data_q;
    dev_fault_d   = dev_fault_q;
    iommu_daddr_d = iommu_daddr_q;
    iommu_we_d    = iommu_we_q;
    iommu_wdata_d = iommu_wdata_q;
    iommu_req_d   = iommu_req_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_id_d    = sel_idx;
          last_grant_d  = sel_idx;
          iommu_daddr_d = sel_daddr;
          iommu_we_d    = sel_we;
          iommu_wdata_d = sel_wdata;
          iommu_req_d   = 1'b1;
          tmo_cnt_d     = '0;
          state_d       = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // done takes precedence over an expiring counter in the same cycle
        if (iommu_translation_done) begin
          dev_paddr_d          = iommu_paddr;
          dev_data_d           = iommu_data_out;
          dev_fault_d          = iommu_fault;
          dev_ack_d[grant_id_q] = 1'b1;
          iommu_req_d          = 1'b0;
          state_d              = RELEASE;
        end else if (tmo_inc == TO_CNT) begin
          tmo_cnt_d            = tmo_inc;
          dev_paddr_d          = '0;
          dev_data_d           = '0;
          dev_fault_d          = 1'b1;
          dev_ack_d[grant_id_q] = 1'b1;
          timeout_err_d        = 1'b1;
          iommu_req_d          = 1'b0;
          state_d              = RELEASE;
        end else begin
          tmo_cnt_d = tmo_inc;
        end
      end
      RELEASE: begin
        iommu_req_d = 1'b0;
        if (!iommu_translation_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_grant_q  <= IDW'(NUM_DEV - 1);
      grant_id_q    <= '0;
      tmo_cnt_q     <= '0;
      dev_ack_q     <= '0;
      dev_paddr_q   <= '0;
      dev_data_q    <= '0;
      dev_fault_q   <= 1'b0;
      iommu_daddr_q <= '0;
      iommu_we_q    <= 1'b0;
      iommu_wdata_q <= '0;
      iommu_req_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_id_q    <= grant_id_d;
      tmo_cnt_q     <= tmo_cnt_d;
      dev_ack_q     <= dev_ack_d;
      dev_paddr_q   <= dev_paddr_d;
      dev_data_q    <= dev_data_d;
      dev_fault_q   <= dev_fault_d;
      iommu_daddr_q <= iommu_daddr_d;
      iommu_we_q    <= iommu_we_d;
      iommu_wdata_q <= iommu_wdata_d;
      iommu_req_q   <= iommu_req_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign dev_ack                 = dev_ack_q;
  assign dev_paddr               = dev_paddr_q;
  assign dev_data                = dev_data_q;
  assign dev_fault               = dev_fault_q;
  assign iommu_daddr             = iommu_daddr_q;
  assign iommu_write_en          = iommu_we_q;
  assign iommu_write_data        = iommu_wdata_q;
  assign iommu_translate_request = iommu_req_q;
  assign grant_id                = grant_id_q;
  assign busy                    = (state_q != IDLE);
  assign timeout_err             = timeout_err_q;
endmodule

// File: tb/tb_iommu_arbiter.sv
// Bench for iommu_arbiter: directed vector table, reset corner cases and a
// randomized phase scored against a round-robin/timeout reference model.
module tb_iommu_arbiter;
  localparam int NUM_DEV = 4;
  localparam int TIMEOUT = 8;

  logic               clk;
  logic               reset;
  logic [NUM_DEV-1:0] dev_req;
  logic [NUM_DEV*32-1:0] dev_daddr;
  logic [NUM_DEV-1:0] dev_write_en;
  logic [NUM_DEV*32-1:0] dev_write_data;
  logic [NUM_DEV-1:0] dev_ack;
  logic [31:0]        dev_paddr;
  logic [31:0]        dev_data;
  logic               dev_fault;
  logic [31:0]        iommu_daddr;
  logic               iommu_write_en;
  logic [31:0]        iommu_write_data;
  logic               iommu_translate_request;
  logic [31:0]        iommu_paddr;
  logic [31:0]        iommu_data_out;
  logic               iommu_translation_done;
  logic               iommu_fault;
  logic [1:0]         grant_id;
  logic               busy;
  logic               timeout_err;

  iommu_arbiter #(.NUM_DEV(NUM_DEV), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .dev_req(dev_req), .dev_daddr(dev_daddr), .dev_write_en(dev_write_en),
    .dev_write_data(dev_write_data), .dev_ack(dev_ack), .dev_paddr(dev_paddr),
    .dev_data(dev_data), .dev_fault(dev_fault), .iommu_daddr(iommu_daddr),
    .iommu_write_en(iommu_write_en), .iommu_write_data(iommu_write_data),
    .iommu_translate_request(iommu_translate_request),
    .iommu_paddr(iommu_paddr), .iommu_data_out(iommu_data_out),
    .iommu_translation_done(iommu_translation_done), .iommu_fault(iommu_fault),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // expected {timed_out, device} per transaction from the reference model
  logic [2:0] exp_q[$];

  typedef struct {
    logic [3:0]  req;
    int          k;       // cycles after grant before done is driven
    logic [31:0] gaddr;
    logic [31:0] pa;
    logic [31:0] pd;
    logic        flt;
    int          hold;    // extra cycles done stays high after the ack
    logic        drop;    // granted device drops dev_req mid-transaction
    int          exp_dev;
    logic        exp_tmo;
    logic        exp_te;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dev_req = '0;
    iommu_translation_done = 1'b0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  // ---------------- reference model ----------------
  function automatic int rr_pick(input int last, input logic [3:0] req);
    for (int i = 1; i <= NUM_DEV; i++) begin
      int c;
      logic [1:0] ci;
      c  = (last + i) % NUM_DEV;
      ci = 2'(c);
      if (req[ci]) return c;
    end
    return -1;
  endfunction

  // ---------------- driver + checker for one transaction ----------------
  task automatic run_txn(input logic [3:0] req, input int k, input logic [31:0] gaddr,
                         input logic [31:0] pa, input logic [31:0] pd, input logic flt,
                         input int hold, input logic drop, input int exp_dev,
                         input logic exp_tmo, input logic exp_te);
    int lat;
    int ack_n;
    int exp_n;
    logic [31:0] exp_wd;
    logic exp_we;
    logic [31:0] exp_pa;
    logic [31:0] exp_pd;
    logic exp_f;
    for (int i = 0; i < NUM_DEV; i++) begin
      dev_daddr[32*i +: 32]      = $urandom;
      dev_write_data[32*i +: 32] = $urandom;
      dev_write_en[i]            = 1'($urandom_range(0, 1));
    end
    dev_daddr[32*exp_dev +: 32] = gaddr;
    exp_wd = dev_write_data[32*exp_dev +: 32];
    exp_we = dev_write_en[2'(exp_dev)];
    iommu_paddr    = pa;
    iommu_data_out = pd;
    iommu_fault    = flt;
    iommu_translation_done = 1'b0;
    dev_req = req;

    lat = 0;
    for (int n = 1; n <= 4; n++) begin
      step();
      if (iommu_translate_request) begin
        lat = n;
        break;
      end
    end
    chk("grant_latency", lat, 1);
    if (lat == 0) begin
      do_reset();
      return;
    end
    chk("grant_id", 32'(grant_id), exp_dev);
    chk("iommu_daddr", iommu_daddr, gaddr);
    chk("iommu_write_en", 32'(iommu_write_en), 32'(exp_we));
    chk("iommu_write_data", iommu_write_data, exp_wd);
    chk("busy_granted", 32'(busy), 1);
    if (drop) dev_req = dev_req & ~(4'(1) << exp_dev);

    exp_n = exp_tmo ? TIMEOUT : k + 1;
    iommu_translation_done = (k == 0);
    ack_n = 0;
    for (int n = 1; n <= TIMEOUT + 2; n++) begin
      step();
      if (dev_ack != '0) begin
        ack_n = n;
        break;
      end
      chk("req_held", 32'(iommu_translate_request), 1);
      chk("daddr_stable_wait", iommu_daddr, gaddr);
      iommu_translation_done = (n >= k);
    end
    chk("ack_cycle", ack_n, exp_n);
    if (ack_n == 0) begin
      do_reset();
      return;
    end
    exp_pa = exp_tmo ? 32'h0 : pa;
    exp_pd = exp_tmo ? 32'h0 : pd;
    exp_f  = exp_tmo ? 1'b1 : flt;
    chk("dev_ack", 32'(dev_ack), 32'(1) << exp_dev);
    chk("dev_paddr", dev_paddr, exp_pa);
    chk("dev_data", dev_data, exp_pd);
    chk("dev_fault", 32'(dev_fault), 32'(exp_f));
    chk("timeout_err", 32'(timeout_err), 32'(exp_te));
    chk("req_dropped", 32'(iommu_translate_request), 0);
    chk("daddr_stable_ack", iommu_daddr, gaddr);

    if (iommu_translation_done) begin
      for (int j = 0; j < hold; j++) begin
        step();
        chk("release_busy", 32'(busy), 1);
        chk("release_no_ack", 32'(dev_ack), 0);
        chk("release_no_grant", 32'(iommu_translate_request), 0);
        chk("daddr_stable_rel", iommu_daddr, gaddr);
      end
    end
    iommu_translation_done = 1'b0;
    step();
    chk("idle_after_release", 32'(busy), 0);
    chk("ack_one_cycle", 32'(dev_ack), 0);
    chk("paddr_held", dev_paddr, exp_pa);
    chk("data_held", dev_data, exp_pd);
    chk("fault_held", 32'(dev_fault), 32'(exp_f));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int last;
    logic te;
    logic [3:0] req;
    int k;
    int dev;
    logic tmo;
    logic [2:0] e;

    reset = 1'b1;
    dev_req = '0;
    dev_daddr = '0;
    dev_write_en = '0;
    dev_write_data = '0;
    iommu_paddr = '0;
    iommu_data_out = '0;
    iommu_translation_done = 1'b0;
    iommu_fault = 1'b0;

    //          req      k   gaddr          pa             pd             flt  hold drop dev tmo te
    tbl[0]  = '{4'b1111, 1,  32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0};
    tbl[1]  = '{4'b1111, 0,  32'h1000_0100, 32'h2000_0100, 32'h3000_0100, 1'b0, 0, 1'b0, 1, 1'b0, 1'b0};
    tbl[2]  = '{4'b1111, 2,  32'h1000_0200, 32'h2000_0200, 32'h3000_0200, 1'b0, 1, 1'b0, 2, 1'b0, 1'b0};
    tbl[3]  = '{4'b1111, 0,  32'h1000_0300, 32'h2000_0300, 32'h3000_0300, 1'b0, 0, 1'b0, 3, 1'b0, 1'b0};
    tbl[4]  = '{4'b1111, 1,  32'h1000_0400, 32'h2000_0400, 32'h3000_0400, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0};
    tbl[5]  = '{4'b1010, 0,  32'h1000_0500, 32'h2000_0500, 32'h3000_0500, 1'b0, 0, 1'b0, 1, 1'b0, 1'b0};
    tbl[6]  = '{4'b1010, 3,  32'h1000_0600, 32'h2000_0600, 32'h3000_0600, 1'b0, 2, 1'b0, 3, 1'b0, 1'b0};
    tbl[7]  = '{4'b0001, 0,  32'h0040_1234, 32'h0080_0234, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0};
    tbl[8]  = '{4'b0100, 7,  32'h1000_0800, 32'h2000_0800, 32'h3000_0800, 1'b0, 0, 1'b0, 2, 1'b0, 1'b0};
    tbl[9]  = '{4'b0100, 1,  32'h1000_0900, 32'h2000_0900, 32'h3000_0900, 1'b1, 3, 1'b1, 2, 1'b0, 1'b0};
    tbl[10] = '{4'b1000, 99, 32'h1000_0A00, 32'h5555_5555, 32'hAAAA_AAAA, 1'b0, 0, 1'b0, 3, 1'b1, 1'b1};
    tbl[11] = '{4'b0110, 8,  32'h1000_0B00, 32'h2000_0B00, 32'h3000_0B00, 1'b0, 0, 1'b0, 1, 1'b1, 1'b1};
    tbl[12] = '{4'b0011, 4,  32'h1000_0C00, 32'h2000_0C00, 32'h3000_0C00, 1'b0, 1, 1'b1, 0, 1'b0, 1'b1};

    repeat (3) step();
    chk("rst_dev_ack", 32'(dev_ack), 0);
    chk("rst_dev_paddr", dev_paddr, 0);
    chk("rst_dev_data", dev_data, 0);
    chk("rst_dev_fault", 32'(dev_fault), 0);
    chk("rst_iommu_daddr", iommu_daddr, 0);
    chk("rst_iommu_we", 32'(iommu_write_en), 0);
    chk("rst_iommu_wdata", iommu_write_data, 0);
    chk("rst_iommu_req", 32'(iommu_translate_request), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 13; i++)
      run_txn(tbl[i].req, tbl[i].k, tbl[i].gaddr, tbl[i].pa, tbl[i].pd, tbl[i].flt,
              tbl[i].hold, tbl[i].drop, tbl[i].exp_dev, tbl[i].exp_tmo, tbl[i].exp_te);

    // reset while waiting for translation: request drops, no ack appears
    dev_req = 4'b0010;
    step();
    chk("mid_grant_req", 32'(iommu_translate_request), 1);
    chk("mid_grant_id", 32'(grant_id), 1);
    chk("te_sticky", 32'(timeout_err), 1);
    reset = 1'b1;
    iommu_translation_done = 1'b1;
    step();
    chk("mid_rst_req", 32'(iommu_translate_request), 0);
    chk("mid_rst_ack", 32'(dev_ack), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_te", 32'(timeout_err), 0);
    chk("mid_rst_grant", 32'(grant_id), 0);
    chk("mid_rst_daddr", iommu_daddr, 0);
    step();
    chk("mid_rst_ack2", 32'(dev_ack), 0);
    reset = 1'b0;
    iommu_translation_done = 1'b0;
    dev_req = '0;
    step();
    chk("post_rst_ack", 32'(dev_ack), 0);
    run_txn(4'b1111, 0, 32'h7000_0000, 32'h7100_0000, 32'h7200_0000, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);

    // randomized phase against the reference model
    last = 0;
    te = 1'b0;
    for (int t = 0; t < 40; t++) begin
      req = 4'($urandom_range(1, 15));
      k = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 5) : $urandom_range(0, TIMEOUT + 3);
      dev = rr_pick(last, req);
      last = dev;
      tmo = (k >= TIMEOUT);
      te = te | tmo;
      exp_q.push_back({tmo, 2'(dev)});
      e = exp_q.pop_front();
      run_txn(req, k, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), int'(e[1:0]), e[2], te);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/iommu_arbiter.md
IOMMU_ARBITER -- requirements
Module: iommu_arbiter

Interface
REQ-001 Parameter NUM_DEV, default 4, number of DMA requesters (2..8).
REQ-002 Parameter TIMEOUT, default 255, max cycles waiting for translation_done (1..255).
REQ-003 Single clock domain; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 dev_req  in  NUM_DEV  per-device level request, held until dev_ack.
REQ-007 dev_daddr  in  NUM_DEV*32  device virtual addresses; device i at bits [32i+31:32i].
REQ-008 dev_write_en  in  NUM_DEV  per-device write flag.
REQ-009 dev_write_data  in  NUM_DEV*32  per-device write data, packed as dev_daddr.
REQ-010 dev_ack  out  NUM_DEV  one-cycle completion pulse, one-hot.
REQ-011 dev_paddr  out  32  translated physical address, valid with dev_ack.
REQ-012 dev_data  out  32  read data, valid with dev_ack when the write flag was 0.
REQ-013 dev_fault  out  1  translation fault or timeout, valid with dev_ack.
REQ-014 iommu_daddr, iommu_write_en, iommu_write_data  out  32/1/32  to the IOMMU.
REQ-015 iommu_translate_request  out  1  level request to the IOMMU.
REQ-016 iommu_paddr, iommu_data_out  in  32/32  IOMMU results.
REQ-017 iommu_translation_done, iommu_fault  in  1/1  IOMMU status.
REQ-018 grant_id  out  clog2(NUM_DEV)  index of the current or last granted device.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 timeout_err  out  1  sticky flag, set on any timeout, cleared only by reset.

Function
REQ-021 FSM states: IDLE, WAIT_DONE, RELEASE.
REQ-022 IDLE with any dev_req bit high:
- Select a device round-robin, searching from last_grant+1 modulo NUM_DEV.
- Register that device's daddr, write_en and write_data onto the iommu_* outputs.
- Set grant_id, last_grant and iommu_translate_request=1; clear the timeout counter; go to WAIT_DONE.
REQ-023 Latency: request seen in IDLE at edge T -> iommu_translate_request high after edge T.
REQ-024 iommu_daddr, iommu_write_en and iommu_write_data SHALL stay constant from grant until the return to IDLE; the IOMMU samples daddr in more than one state.
REQ-025 WAIT_DONE with iommu_translation_done=1:
- Register iommu_paddr into dev_paddr, iommu_data_out into dev_data and iommu_fault into dev_fault.
- Pulse dev_ack[grant_id] for exactly one cycle; drop iommu_translate_request; go to RELEASE.
REQ-026 WAIT_DONE timeout: the 8-bit counter increments each cycle done is low. When it equals TIMEOUT:
- dev_fault=1, dev_paddr=0, dev_data=0.
- Pulse dev_ack[grant_id]; set timeout_err; drop iommu_translate_request; go to RELEASE.
REQ-027 If done and timeout occur in the same cycle, done wins and timeout_err is not set.
REQ-028 RELEASE: hold iommu_translate_request=0; go to IDLE on the first cycle iommu_translation_done=0, which guarantees the IOMMU is back in IDLE before the next grant.
REQ-029 dev_req sampling: requests are sampled only in IDLE. A device dropping dev_req while granted does not abort the transaction; its dev_ack still pulses.
REQ-030 A device that keeps dev_req high after its ack is re-arbitrated at the lowest priority; there are no back-to-back grants to it while others request.
REQ-031 dev_paddr, dev_data and dev_fault hold their values until the next ack.
REQ-032 A minimum of one IDLE cycle separates consecutive grants.

Reset
REQ-033 While reset is high, on each clk edge: state=IDLE, last_grant=NUM_DEV-1, grant_id=0, timeout counter=0.
REQ-034 While reset is high, all outputs are 0: dev_ack, dev_paddr, dev_data, dev_fault, iommu_*, busy and timeout_err.
REQ-035 Reset asserted mid-transaction drops iommu_translate_request on the next edge and emits no dev_ack.

Verification
REQ-036 Single read:
- Stimulus: dev_req=0001, dev_daddr[0]=0x0040_1234; IOMMU returns done with paddr=0x0080_0234, data=0xDEAD_BEEF.
- Response: dev_ack=0001 for 1 cycle, dev_paddr=0x0080_0234, dev_data=0xDEAD_BEEF, dev_fault=0.
REQ-037 Round-robin:
- Stimulus: dev_req=1111 held continuously.
- Response: grant order 0,1,2,3,0.
REQ-038 Round-robin with gaps:
- Stimulus: dev_req=1010.
- Response: grants 1 then 3.
REQ-039 Fault passthrough:
- Stimulus: iommu_fault=1 with done.
- Response: dev_fault=1 and dev_ack pulses.
REQ-040 Timeout:
- Stimulus: TIMEOUT=8, done never asserted.
- Response: dev_ack pulses with dev_fault=1, and timeout_err=1 persists until reset.
REQ-041 Release gating and reset:
- Stimulus: hold done high 3 cycles after the request drops.
- Response: no new grant until done=0, and iommu_daddr is stable throughout.
- Stimulus: reset in WAIT_DONE.
- Response: iommu_translate_request=0 on the next edge and no ack.
